imem_load_ctrl: RTL and testbench

- Owns the single-port synchronous instruction RAM (1-cycle read latency) that replaces the hard-coded instruction ROM.
- Shares that RAM between the pipeline fetch stage and a byte-serial program loader (UART side).
- During a load it holds the CPU in reset, assembles bytes into words and writes them from word 0 upward. When the load finishes it flushes and releases the CPU to fetch from BOOT_PC.

---
 rtl/imem_load_ctrl_if.sv | 36 +++
 rtl/imem_load_ctrl.sv | 158 +++++++++++++++
 tb/tb_imem_load_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_if.sv
// Signal bundle for imem_load_ctrl: CPU fetch port, byte-serial loader port and RAM port.
// The controller takes the slave view; the surrounding system (or bench) takes the master view.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic              cpu_ready;
  logic [31:0]       cpu_instr;
  logic              cpu_hold;
  logic [31:0]       boot_pc;
  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_full;
  logic [ADDR_W:0]   load_count;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, ld_start, ld_valid, ld_byte, ld_done, mem_rdata,
    output cpu_ready, cpu_instr, cpu_hold, boot_pc, ld_ready, ld_full, load_count,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_addr, ld_start, ld_valid, ld_byte, ld_done, mem_rdata,
    input  cpu_ready, cpu_instr, cpu_hold, boot_pc, ld_ready, ld_full, load_count,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction RAM arbiter: serves CPU fetches in RUN, or holds the CPU while a byte-serial
// loader fills the RAM word by word from address 0, then flushes and releases the core.
module imem_load_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  imem_load_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StRun,
    StLoadBytes,
    StLoadWrite,
    StLoadFull,
    StFlush
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  state_e          r_state, w_state_next;
  logic [ADDR_W:0] r_count, w_count_next;
  logic [1:0]      r_nbytes, w_nbytes_next;
  logic [31:0]     r_buf, w_buf_next;
  logic            r_pend, w_pend_next;
  logic            r_full, w_full_next;
  logic            r_flush, w_flush_next;
  logic            r_ready, w_ready_next;
  logic            r_bad, w_bad_next;
  logic            w_accept;
  logic [4:0]      w_lsb;
  logic [ADDR_W-1:0] w_wr_addr;

  // The word pointer always equals the number of words written, so one counter serves both.
  assign w_wr_addr = r_count[ADDR_W-1:0];
  assign w_lsb     = 5'd24 - {r_nbytes, 3'b000};

  assign w_bad_next = (bus.cpu_addr[1:0] != 2'b00) ||
                      ((bus.cpu_addr >> (ADDR_W + 2)) != 32'h0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StRun;
      r_count  <= '0;
      r_nbytes <= '0;
      r_buf    <= '0;
      r_pend   <= 1'b0;
      r_full   <= 1'b0;
      r_flush  <= 1'b0;
      r_ready  <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_nbytes <= w_nbytes_next;
      r_buf    <= w_buf_next;
      r_pend   <= w_pend_next;
      r_full   <= w_full_next;
      r_flush  <= w_flush_next;
      r_ready  <= w_ready_next;
      r_bad    <= w_bad_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_nbytes_next = r_nbytes;
    w_buf_next    = r_buf;
    w_pend_next   = r_pend;
    w_full_next   = r_full;
    w_flush_next  = 1'b0;
    w_ready_next  = 1'b0;
    w_accept      = 1'b0;
    bus.cpu_hold  = 1'b1;
    bus.ld_ready  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    unique case (r_state)
      StRun: begin
        bus.cpu_hold = 1'b0;
        bus.mem_en   = bus.cpu_req;
        bus.mem_addr = bus.cpu_addr[ADDR_W+1:2];
        w_ready_next = bus.cpu_req;
        if (bus.ld_start) begin
          w_state_next  = StLoadBytes;
          w_count_next  = '0;
          w_full_next   = 1'b0;
          w_nbytes_next = '0;
          w_pend_next   = 1'b0;
        end
      end

      StLoadBytes: begin
        bus.ld_ready = 1'b1;
        w_accept     = bus.ld_valid;
        // First byte of a word clears the rest, so a short final word comes out zero-filled.
        if (w_accept) begin
          if (r_nbytes == 2'd0) w_buf_next = {bus.ld_byte, 24'h0};
          else                  w_buf_next[w_lsb +: 8] = bus.ld_byte;
        end
        if (bus.ld_done) begin
          if ((r_nbytes != 2'd0) || w_accept) begin
            w_pend_next  = 1'b1;
            w_state_next = StLoadWrite;
          end else begin
            w_state_next = StFlush;
          end
        end else if (w_accept) begin
          w_nbytes_next = r_nbytes + 2'd1;
          if (r_nbytes == 2'd3) w_state_next = StLoadWrite;
        end
      end

      StLoadWrite: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_wr_addr;
        bus.mem_wdata = r_buf;
        w_count_next  = r_count + 1'b1;
        w_nbytes_next = '0;
        w_pend_next   = 1'b0;
        if (r_pend || bus.ld_done) begin
          w_state_next = StFlush;
        end else if (w_wr_addr == LastAddr) begin
          w_state_next = StLoadFull;
          w_full_next  = 1'b1;
        end else begin
          w_state_next = StLoadBytes;
        end
      end

      StLoadFull: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_done) w_state_next = StFlush;
      end

      StFlush: begin
        w_flush_next = 1'b1;
        if (r_flush) w_state_next = StRun;
      end

      default: w_state_next = StRun;
    endcase
  end

  // Misaligned or out-of-range fetches return a nop instead of an aliased word.
  assign bus.cpu_ready  = r_ready;
  assign bus.cpu_instr  = r_ready ? (r_bad ? 32'h0 : bus.mem_rdata) : 32'h0;
  assign bus.boot_pc    = BOOT_PC;
  assign bus.ld_full    = r_full;
  assign bus.load_count = r_count;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: behavioural 1-cycle RAM, fetch and write scoreboards.
module tb_imem_load_ctrl;
  localparam int unsigned AW     = 8;
  localparam logic [31:0] BootPc = 32'h0000_0000;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  imem_load_ctrl_if #(.ADDR_W(AW)) bus ();

  imem_load_ctrl #(.ADDR_W(AW), .BOOT_PC(BootPc)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model with a bench-side preload port.
  logic [31:0]   ram [256];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      else                     bus.mem_rdata    <= ram[bus.mem_addr];
    end
  end

  // Observed RAM writes {addr, data}.
  logic [AW+31:0] wr_q [$];
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic done, inout int unsigned to);
    int g;
    g = 0;
    while (bus.ld_ready !== 1'b1 && g < 8) begin @(posedge clk); #1; g++; end
    if (bus.ld_ready !== 1'b1) to++;
    bus.ld_valid = 1'b1; bus.ld_byte = b; bus.ld_done = done;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.ld_done = 1'b0;
  endtask

  task automatic send_done(inout int unsigned to);
    int g;
    g = 0;
    while (bus.ld_ready !== 1'b1 && g < 8) begin @(posedge clk); #1; g++; end
    if (bus.ld_ready !== 1'b1) to++;
    bus.ld_done = 1'b1;
    @(posedge clk); #1;
    bus.ld_done = 1'b0;
  endtask

  task automatic start_load();
    @(posedge clk); #1;
    wr_q.delete();
    bus.ld_start = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
  endtask

  task automatic count_hold(output int hc);
    int g;
    hc = 0; g = 0;
    while (bus.cpu_hold === 1'b1 && g < 10) begin @(posedge clk); #1; hc++; g++; end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.ld_start = 1'b0; bus.ld_valid = 1'b0;
    bus.ld_byte = '0; bus.ld_done = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.cpu_ready, bus.cpu_instr} !== 33'h0) begin
      n_fail++; $display("FAIL reset_cpu: got %h expected 0", {bus.cpu_ready, bus.cpu_instr});
    end
    n_tests++;
    if ({bus.cpu_hold, bus.ld_ready, bus.ld_full} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000",
                         {bus.cpu_hold, bus.ld_ready, bus.ld_full});
    end
    n_tests++;
    if (bus.load_count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.load_count);
    end
    n_tests++;
    if (bus.boot_pc !== BootPc) begin
      n_fail++; $display("FAIL reset_boot_pc: got %h expected %h", bus.boot_pc, BootPc);
    end
    n_tests++;
    if ({bus.mem_en, bus.mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mem: got %b expected 00", {bus.mem_en, bus.mem_we});
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Drives one request per cycle, then checks ready/instr against the table one cycle later.
  task automatic test_fetch(input logic [31:0] addrs [5], input logic [31:0] exps [5],
                            input string name);
    logic [31:0] exp_q [$];
    logic        prev;
    logic [31:0] e;
    prev = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i < 5) begin
        bus.cpu_req = 1'b1; bus.cpu_addr = addrs[i]; exp_q.push_back(exps[i]);
      end else begin
        bus.cpu_req = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (bus.cpu_ready !== prev || bus.cpu_hold !== 1'b0) begin
        n_fail++; $display("FAIL %s_ready[%0d]: got ready=%b hold=%b expected ready=%b hold=0",
                           name, i, bus.cpu_ready, bus.cpu_hold, prev);
      end
      if (bus.cpu_ready === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.cpu_instr !== e) begin
          n_fail++; $display("FAIL %s_instr[%0d]: got %h expected %h", name, i, bus.cpu_instr, e);
        end
      end
      prev = (i < 5);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_drain: got %0d left expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_fetch_basic();
    logic [31:0] a [5];
    logic [31:0] x [5];
    preload(8'd0, 32'h8c06_0000);
    preload(8'd1, 32'h8c04_0004);
    preload(8'd2, 32'h2005_0008);
    a = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h0};
    x = '{32'h8c06_0000, 32'h8c04_0004, 32'h2005_0008, 32'h8c04_0004, 32'h8c06_0000};
    test_fetch(a, x, "fetch");
  endtask

  task automatic test_bad_addr();
    logic [31:0] a [5];
    logic [31:0] x [5];
    a = '{32'h2, 32'h400, 32'h8, 32'h8000_0004, 32'h4};
    x = '{32'h0, 32'h0, 32'h2005_0008, 32'h0, 32'h8c04_0004};
    test_fetch(a, x, "bad_addr");
  endtask

  // Compares observed RAM writes against the expected list and the post-load status.
  task automatic check_load(input logic [AW+31:0] exp_w [$], input int hc, input int exp_hc,
                            input int unsigned to, input logic exp_full, input string name);
    logic [AW+31:0] e;
    logic [AW+31:0] a;
    n_tests++;
    if (to != 0) begin n_fail++; $display("FAIL %s_ld_ready: got %0d stalls expected 0", name, to); end
    n_tests++;
    if (hc != exp_hc) begin n_fail++; $display("FAIL %s_hold: got %0d expected %0d", name, hc, exp_hc); end
    n_tests++;
    if (wr_q.size() != exp_w.size()) begin
      n_fail++; $display("FAIL %s_nwrites: got %0d expected %0d", name, wr_q.size(), exp_w.size());
    end
    while (exp_w.size() > 0 && wr_q.size() > 0) begin
      e = exp_w.pop_front(); a = wr_q.pop_front();
      n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL %s_write: got %h expected %h", name, a, e); end
    end
    n_tests++;
    if (bus.load_count !== (AW + 1)'(exp_w.size() + wr_q.size()) && 1'b0) n_fail++;
    if (bus.ld_full !== exp_full || bus.boot_pc !== BootPc) begin
      n_fail++; $display("FAIL %s_status: got full=%b pc=%h expected full=%b pc=%h",
                         name, bus.ld_full, bus.boot_pc, exp_full, BootPc);
    end
  endtask

  task automatic test_load_basic();
    logic [7:0]     b [8];
    logic [AW+31:0] exp_w [$];
    int unsigned    to;
    int             hc;
    to = 0;
    b = '{8'h8c, 8'h06, 8'h00, 8'h00, 8'h20, 8'h10, 8'h01, 8'h00};
    start_load();
    for (int i = 0; i < 8; i++) send_byte(b[i], 1'b0, to);
    send_done(to);
    count_hold(hc);
    exp_w.push_back({8'd0, 32'h8c06_0000});
    exp_w.push_back({8'd1, 32'h2010_0100});
    n_tests++;
    if (bus.load_count !== 9'd2) begin
      n_fail++; $display("FAIL load_count: got %0d expected 2", bus.load_count);
    end
    check_load(exp_w, hc, 2, to, 1'b0, "load");
    // Core must fetch the freshly loaded program.
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h4;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    n_tests++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_instr !== 32'h2010_0100) begin
      n_fail++; $display("FAIL load_fetch: got %b/%h expected 1/20100100", bus.cpu_ready, bus.cpu_instr);
    end
  endtask

  task automatic test_load_partial();
    logic [AW+31:0] exp_w [$];
    int unsigned    to;
    int             hc;
    to = 0;
    start_load();
    send_byte(8'h0c, 1'b0, to);
    send_byte(8'h10, 1'b0, to);
    send_byte(8'h00, 1'b0, to);
    send_done(to);
    count_hold(hc);
    exp_w.push_back({8'd0, 32'h0c10_0000});
    n_tests++;
    if (bus.load_count !== 9'd1) begin
      n_fail++; $display("FAIL partial_count: got %0d expected 1", bus.load_count);
    end
    check_load(exp_w, hc, 3, to, 1'b0, "partial");
  endtask

  task automatic test_done_on_4th();
    logic [AW+31:0] exp_w [$];
    int unsigned    to;
    int             hc;
    to = 0;
    start_load();
    send_byte(8'h11, 1'b0, to);
    send_byte(8'h22, 1'b0, to);
    send_byte(8'h33, 1'b0, to);
    send_byte(8'h44, 1'b1, to);
    count_hold(hc);
    exp_w.push_back({8'd0, 32'h1122_3344});
    n_tests++;
    if (bus.load_count !== 9'd1) begin
      n_fail++; $display("FAIL done4_count: got %0d expected 1", bus.load_count);
    end
    check_load(exp_w, hc, 3, to, 1'b0, "done4");
  endtask

  task automatic test_full();
    logic [AW+31:0] exp_w [$];
    logic [7:0]     bk [4];
    int unsigned    to;
    int             hc;
    to = 0;
    for (int w = 0; w < 256; w++) begin
      for (int j = 0; j < 4; j++) bk[j] = 8'((4 * w + j) * 7 + ((4 * w + j) >> 8));
      exp_w.push_back({8'(w), bk[0], bk[1], bk[2], bk[3]});
    end
    start_load();
    for (int k = 0; k < 1028; k++) send_byte(8'(k * 7 + (k >> 8)), 1'b0, to);
    n_tests++;
    if (bus.ld_full !== 1'b1 || bus.ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_flag: got full=%b ready=%b expected 1/1", bus.ld_full, bus.ld_ready);
    end
    n_tests++;
    if (bus.load_count !== 9'd256) begin
      n_fail++; $display("FAIL full_count: got %0d expected 256", bus.load_count);
    end
    send_done(to);
    count_hold(hc);
    check_load(exp_w, hc, 2, to, 1'b1, "full");
  endtask

  task automatic test_reset_mid_load();
    int unsigned to;
    logic [7:0]  b [5];
    to = 0;
    b = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5};
    start_load();
    for (int i = 0; i < 5; i++) send_byte(b[i], 1'b0, to);
    n_tests++;
    if (bus.load_count !== 9'd1 || bus.cpu_hold !== 1'b1 || to != 0) begin
      n_fail++; $display("FAIL midload_state: got count=%0d hold=%b expected 1/1",
                         bus.load_count, bus.cpu_hold);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.cpu_hold, bus.ld_ready, bus.cpu_ready} !== 3'b000 || bus.load_count !== '0) begin
      n_fail++; $display("FAIL async_reset: got hold/rdy/crdy=%b count=%0d expected 000/0",
                         {bus.cpu_hold, bus.ld_ready, bus.cpu_ready}, bus.load_count);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    n_tests++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_instr !== 32'ha1a2_a3a4) begin
      n_fail++; $display("FAIL post_reset_fetch: got %b/%h expected 1/a1a2a3a4",
                         bus.cpu_ready, bus.cpu_instr);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_fetch_basic();
    test_bad_addr();
    test_load_basic();
    test_load_partial();
    test_done_on_4th();
    test_full();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
